// File: rtl/mult_rs.sv
// Reservation station feeding the multiply unit: a collapsing queue of
// micro-ops that snoop the CDB and issue oldest-ready-first.
module mult_rs #(
    parameter int unsigned DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            dispatch_transmit,
    input  logic [7:0]      dispatch_operand,
    input  logic [1:0][3:0] dispatch_tags,
    input  logic [1:0]      dispatch_ready,
    input  logic [1:0][7:0] dispatch_vals,
    input  logic [7:0]      dispatch_wbs,
    input  logic [7:0]      dispatch_flags,
    input  logic [3:0]      dispatch_robid,
    output logic            rs_full,
    input  logic            cdb_transmit,
    input  logic [3:0]      cdb_id,
    input  logic [7:0]      cdb_val,
    input  logic            flush,
    input  logic            fu_busy,
    output logic            issue_transmit,
    output logic [7:0]      issue_operand,
    output logic [1:0][7:0] issue_depvals,
    output logic [7:0]      issue_wbs,
    output logic [7:0]      issue_flags,
    output logic [3:0]      issue_robid
);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic            valid;
        logic [7:0]      operand;
        logic [1:0]      rdy;
        logic [1:0][3:0] tag;
        logic [1:0][7:0] val;
        logic [7:0]      wbs;
        logic [7:0]      flags;
        logic [3:0]      robid;
    } entry_t;

    entry_t           q     [DEPTH];
    entry_t           woken [DEPTH+1];
    entry_t           q_n   [DEPTH];
    entry_t           new_e;
    logic [DEPTH-1:0] at_or_above_sel;
    logic             sel_found;
    logic [7:0]       sel_operand;
    logic [1:0][7:0]  sel_vals;
    logic [7:0]       sel_wbs;
    logic [7:0]       sel_flags;
    logic [3:0]       sel_robid;
    logic             issue_go;
    logic             accept;
    logic [CW-1:0]    count;
    logic [CW-1:0]    count_after;
    logic [CW-1:0]    count_n;

    assign rs_full  = (count == CW'(DEPTH));
    assign accept   = dispatch_transmit && !rs_full;
    assign issue_go = sel_found && !fu_busy && !flush && !rst;

    // Oldest fully-ready entry; also marks every slot at or above it,
    // which is exactly the region that collapses when it issues.
    always_comb begin
        sel_found       = 1'b0;
        sel_operand     = '0;
        sel_vals        = '0;
        sel_wbs         = '0;
        sel_flags       = '0;
        sel_robid       = '0;
        at_or_above_sel = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (!sel_found && q[i].valid && (&q[i].rdy)) begin
                sel_found   = 1'b1;
                sel_operand = q[i].operand;
                sel_vals    = q[i].val;
                sel_wbs     = q[i].wbs;
                sel_flags   = q[i].flags;
                sel_robid   = q[i].robid;
            end
            at_or_above_sel[i] = sel_found;
        end
    end

    always_comb begin
        issue_transmit = issue_go;
        issue_operand  = issue_go ? sel_operand : '0;
        issue_depvals  = issue_go ? sel_vals    : '0;
        issue_wbs      = issue_go ? sel_wbs     : '0;
        issue_flags    = issue_go ? sel_flags   : '0;
        issue_robid    = issue_go ? sel_robid   : '0;
    end

    // Wakeup is applied before the shift so a captured value travels with its entry.
    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            woken[i] = q[i];
            for (int unsigned s = 0; s < 2; s++) begin
                if (q[i].valid && !q[i].rdy[s] && cdb_transmit && (q[i].tag[s] == cdb_id)) begin
                    woken[i].rdy[s] = 1'b1;
                    woken[i].val[s] = cdb_val;
                end
            end
        end
        woken[DEPTH] = '0;
    end

    always_comb begin
        new_e.valid   = 1'b1;
        new_e.operand = dispatch_operand;
        new_e.rdy     = dispatch_ready;
        new_e.tag     = dispatch_tags;
        new_e.val     = dispatch_vals;
        new_e.wbs     = dispatch_wbs;
        new_e.flags   = dispatch_flags;
        new_e.robid   = dispatch_robid;
        for (int unsigned s = 0; s < 2; s++) begin
            if (!dispatch_ready[s] && cdb_transmit && (dispatch_tags[s] == cdb_id)) begin
                new_e.rdy[s] = 1'b1;
                new_e.val[s] = cdb_val;
            end
        end
    end

    always_comb begin
        count_after = count - CW'(issue_go);
        count_n     = count_after + CW'(accept);
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (issue_go && at_or_above_sel[i]) begin
                q_n[i] = woken[i+1];
            end else begin
                q_n[i] = woken[i];
            end
            if (accept && (CW'(i) == count_after)) begin
                q_n[i] = new_e;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            count <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                q[i] <= '0;
            end
        end else begin
            count <= count_n;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                q[i] <= q_n[i];
            end
        end
    end
endmodule

// File: tb/tb_mult_rs.sv
// Scoreboard bench for mult_rs: stimulus queues expected issues and per-cycle
// expectations; a negedge monitor compares everything the DUT presents.
module tb_mult_rs;
    logic            clk = 1'b0;
    logic            rst;
    logic            dispatch_transmit;
    logic [7:0]      dispatch_operand;
    logic [1:0][3:0] dispatch_tags;
    logic [1:0]      dispatch_ready;
    logic [1:0][7:0] dispatch_vals;
    logic [7:0]      dispatch_wbs;
    logic [7:0]      dispatch_flags;
    logic [3:0]      dispatch_robid;
    logic            rs_full;
    logic            cdb_transmit;
    logic [3:0]      cdb_id;
    logic [7:0]      cdb_val;
    logic            flush;
    logic            fu_busy;
    logic            issue_transmit;
    logic [7:0]      issue_operand;
    logic [1:0][7:0] issue_depvals;
    logic [7:0]      issue_wbs;
    logic [7:0]      issue_flags;
    logic [3:0]      issue_robid;

    typedef struct packed {
        logic [7:0]      op;
        logic [1:0][7:0] dv;
        logic [7:0]      wbs;
        logic [7:0]      flags;
        logic [3:0]      robid;
    } exp_t;

    exp_t sb[$];
    logic exp_tx   = 1'b0;
    logic exp_full = 1'b0;
    logic done     = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    mult_rs #(.DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .dispatch_transmit(dispatch_transmit), .dispatch_operand(dispatch_operand),
        .dispatch_tags(dispatch_tags), .dispatch_ready(dispatch_ready),
        .dispatch_vals(dispatch_vals), .dispatch_wbs(dispatch_wbs),
        .dispatch_flags(dispatch_flags), .dispatch_robid(dispatch_robid),
        .rs_full(rs_full), .cdb_transmit(cdb_transmit), .cdb_id(cdb_id),
        .cdb_val(cdb_val), .flush(flush), .fu_busy(fu_busy),
        .issue_transmit(issue_transmit), .issue_operand(issue_operand),
        .issue_depvals(issue_depvals), .issue_wbs(issue_wbs),
        .issue_flags(issue_flags), .issue_robid(issue_robid)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        check("issue_transmit", 32'(issue_transmit), 32'(exp_tx));
        check("rs_full", 32'(rs_full), 32'(exp_full));
        if (issue_transmit) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_issue: robid %0h issued, none expected", issue_robid);
            end else begin
                e = sb.pop_front();
                check("issue_robid", 32'(issue_robid), 32'(e.robid));
                check("issue_operand", 32'(issue_operand), 32'(e.op));
                check("issue_depvals", 32'(issue_depvals), 32'(e.dv));
                check("issue_wbs", 32'(issue_wbs), 32'(e.wbs));
                check("issue_flags", 32'(issue_flags), 32'(e.flags));
            end
        end else begin
            check("idle_data", 32'({issue_operand, issue_wbs, issue_flags, issue_robid}), 32'h0);
            check("idle_depvals", 32'(issue_depvals), 32'h0);
        end
        if (done) begin
            check("scoreboard_drained", 32'(sb.size()), 32'h0);
            $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
            $finish;
        end
    end

    task automatic cyc(input logic tx, input logic full);
        exp_tx   = tx;
        exp_full = full;
        @(posedge clk);
        #1;
        dispatch_transmit = 1'b0;
        cdb_transmit      = 1'b0;
        flush             = 1'b0;
    endtask

    task automatic disp(input logic [3:0] rid,
                        input logic [3:0] t0, input logic r0, input logic [7:0] v0,
                        input logic [3:0] t1, input logic r1, input logic [7:0] v1);
        dispatch_transmit = 1'b1;
        dispatch_operand  = 8'hA0 | 8'(rid);
        dispatch_tags     = {t1, t0};
        dispatch_ready    = {r1, r0};
        dispatch_vals     = {v1, v0};
        dispatch_wbs      = 8'h10 + 8'(rid);
        dispatch_flags    = 8'h50 + 8'(rid);
        dispatch_robid    = rid;
    endtask

    task automatic cdb(input logic [3:0] id, input logic [7:0] v);
        cdb_transmit = 1'b1;
        cdb_id       = id;
        cdb_val      = v;
    endtask

    task automatic push(input logic [3:0] rid, input logic [7:0] v0, input logic [7:0] v1);
        exp_t e;
        e.op    = 8'hA0 | 8'(rid);
        e.dv    = {v1, v0};
        e.wbs   = 8'h10 + 8'(rid);
        e.flags = 8'h50 + 8'(rid);
        e.robid = rid;
        sb.push_back(e);
    endtask

    task automatic flush_case(input logic use_rst);
        fu_busy = 1'b1;
        disp(4'd1, 4'd3, 1'b0, 8'hEE, 4'd0, 1'b1, 8'h21); cyc(0, 0);
        disp(4'd2, 4'd0, 1'b1, 8'h31, 4'd0, 1'b1, 8'h32); cyc(0, 0);
        disp(4'd3, 4'd0, 1'b1, 8'h41, 4'd0, 1'b1, 8'h42); cyc(0, 0);
        fu_busy = 1'b0;
        disp(4'd4, 4'd0, 1'b1, 8'h01, 4'd0, 1'b1, 8'h02);
        cdb(4'd3, 8'h55);
        if (use_rst) rst = 1'b1;
        else flush = 1'b1;
        cyc(0, 0);
        rst = 1'b0;
        cyc(0, 0); cyc(0, 0); cyc(0, 0);
        // count must restart from zero: full only after four fresh dispatches
        fu_busy = 1'b1;
        for (int k = 0; k < 4; k++) begin
            disp(4'(k + 5), 4'd0, 1'b1, 8'(k), 4'd0, 1'b1, 8'(k));
            cyc(0, 0);
        end
        cyc(0, 1);
        flush = 1'b1;
        cyc(0, 1);
        cyc(0, 0);
        fu_busy = 1'b0;
        cyc(0, 0);
    endtask

    initial begin
        rst = 1'b1; fu_busy = 1'b0;
        dispatch_transmit = 1'b0; dispatch_operand = '0; dispatch_tags = '0;
        dispatch_ready = '0; dispatch_vals = '0; dispatch_wbs = '0;
        dispatch_flags = '0; dispatch_robid = '0;
        cdb_transmit = 1'b0; cdb_id = '0; cdb_val = '0; flush = 1'b0;
        cyc(0, 0); cyc(0, 0);
        rst = 1'b0;
        cyc(0, 0);

        // ready dispatch issues the next cycle
        disp(4'd3, 4'd0, 1'b1, 8'd5, 4'd0, 1'b1, 8'd7); push(4'd3, 8'd5, 8'd7);
        cyc(0, 0); cyc(1, 0); cyc(0, 0);

        // wakeup two cycles after dispatch
        disp(4'd1, 4'd9, 1'b0, 8'hEE, 4'd0, 1'b1, 8'd4);
        cyc(0, 0); cyc(0, 0);
        cdb(4'd9, 8'd6); push(4'd1, 8'd6, 8'd4);
        cyc(0, 0); cyc(1, 0); cyc(0, 0);

        // age order under busy
        fu_busy = 1'b1;
        disp(4'd2, 4'd5, 1'b0, 8'hEE, 4'd0, 1'b1, 8'd3); cyc(0, 0);
        disp(4'd4, 4'd0, 1'b1, 8'd8, 4'd0, 1'b1, 8'd9); cyc(0, 0);
        cdb(4'd5, 8'h22); cyc(0, 0);
        push(4'd2, 8'h22, 8'd3); push(4'd4, 8'd8, 8'd9);
        cyc(0, 0);
        fu_busy = 1'b0; cyc(1, 0);
        fu_busy = 1'b1; cyc(0, 0);
        fu_busy = 1'b0; cyc(1, 0);
        cyc(0, 0);

        // dispatch-time bypass
        disp(4'd6, 4'd7, 1'b0, 8'hEE, 4'd0, 1'b1, 8'd2); cdb(4'd7, 8'h11);
        push(4'd6, 8'h11, 8'd2);
        cyc(0, 0); cyc(1, 0); cyc(0, 0);

        // both sources wake on one broadcast
        disp(4'd8, 4'hA, 1'b0, 8'hEE, 4'hA, 1'b0, 8'hEE); cyc(0, 0);
        cdb(4'hA, 8'h33); push(4'd8, 8'h33, 8'h33);
        cyc(0, 0); cyc(1, 0); cyc(0, 0);

        // fill, drop while full, drain in order
        fu_busy = 1'b1;
        for (int k = 0; k < 4; k++) begin
            disp(4'(10 + k), 4'd0, 1'b1, 8'(k + 1), 4'd0, 1'b1, 8'(8'h40 + k));
            push(4'(10 + k), 8'(k + 1), 8'(8'h40 + k));
            cyc(0, 0);
        end
        disp(4'd14, 4'd0, 1'b1, 8'h77, 4'd0, 1'b1, 8'h77); cyc(0, 1);
        fu_busy = 1'b0;
        disp(4'd15, 4'd0, 1'b1, 8'h78, 4'd0, 1'b1, 8'h78); cyc(1, 1);
        cyc(1, 0); cyc(1, 0); cyc(1, 0);
        cyc(0, 0);

        flush_case(1'b0);
        flush_case(1'b1);

        exp_tx = 1'b0;
        exp_full = 1'b0;
        done = 1'b1;
    end
endmodule
